// File: rtl/jtdd_pkg.sv
// Shared constants for the JTDD interrupt controller.
//   AW/DW      : CPU register bus address / data widths
//   PEND..POL  : register indices decoded by jtdd_irqctl
package jtdd_pkg;

    localparam int AW = 3;
    localparam int DW = 8;

    localparam logic [AW-1:0] PEND = 3'd0; // pending, R / write-1-to-clear
    localparam logic [AW-1:0] MASK = 3'd1; // mask, R/W
    localparam logic [AW-1:0] SET  = 3'd2; // software set, W (write-1 sets pending)
    localparam logic [AW-1:0] OVF  = 3'd3; // overflow, R / write-1-to-clear
    localparam logic [AW-1:0] VEC  = 3'd4; // vector, R
    localparam logic [AW-1:0] POL  = 3'd5; // edge polarity, R/W (1 = falling)

endpackage

// File: rtl/jtdd_irqctl_if.sv
// CPU register bus for jtdd_irqctl.
//   cen  : bus cycle enable, qualifies writes
//   cs   : register block select
//   wr   : write strobe
//   addr : register index
//   din  : write data
//   dout : read data (combinational from the slave)
interface jtdd_irqctl_if;
    import jtdd_pkg::*;

    logic          cen;
    logic          cs;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    modport master (output cen, cs, wr, addr, din, input  dout);
    modport slave  (input  cen, cs, wr, addr, din, output dout);

endinterface

// File: rtl/jtdd_irqctl_ch.sv
// One interrupt channel: optional two-flop synchroniser, edge detector,
// pending latch and overflow latch.
//   clk, rst  : clock, asynchronous active-high reset
//   irq_in    : raw interrupt source
//   polarity  : 0 = rising edge event, 1 = falling edge event
//   sw_set    : software set strobe (already bus-qualified)
//   pend_clr  : pending W1C strobe (already bus-qualified)
//   ovf_clr   : overflow W1C strobe (already bus-qualified)
//   pending   : latched request
//   overflow  : an event arrived while pending was still set
module jtdd_irqctl_ch #(
    parameter int SYNC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic polarity,
    input  logic sw_set,
    input  logic pend_clr,
    input  logic ovf_clr,
    output logic pending,
    output logic overflow
);

    logic level;
    logic hist;
    logic edge_ev;
    logic set_ev;

    generate
        if (SYNC != 0) begin : g_sync
            logic s1;
            logic s2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1 <= 1'b0;
                    s2 <= 1'b0;
                end else begin
                    s1 <= irq_in;
                    s2 <= s1;
                end
            end
            assign level = s2;
        end else begin : g_bypass
            assign level = irq_in;
        end
    endgenerate

    // hist follows the level every cycle, so it is always seeded to the
    // current input: a polarity change alone can never look like an edge.
    assign edge_ev = (level != hist) && (level != polarity);
    assign set_ev  = edge_ev | sw_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= 1'b0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            hist <= level;
            // A new event beats a same-cycle clear so it is never lost.
            if (set_ev)
                pending <= 1'b1;
            else if (pend_clr)
                pending <= 1'b0;
            // Overflow only when the event lands on a pending bit that is
            // not being acknowledged in this very cycle.
            if (set_ev && pending && !pend_clr)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/jtdd_irqctl.sv
// Interrupt controller: NCH edge-triggered channels behind a small CPU
// register file with mask, polarity, software set, overflow and vector.
//   clk, rst : clock, asynchronous active-high reset
//   irq_in   : raw interrupt sources, sampled every clk
//   bus      : CPU register bus (slave side)
//   irq_n    : active-low request per channel, ~(pending & mask)
//   any_irq  : OR of pending & mask
module jtdd_irqctl
    import jtdd_pkg::*;
#(
    parameter int         NCH      = 3,
    parameter logic [7:0] MASK_RST = 8'hFF,
    parameter int         SYNC     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     irq_in,
    jtdd_irqctl_if.slave       bus,
    output logic [NCH-1:0]     irq_n,
    output logic               any_irq
);

    logic           we;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] polarity;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] overflow;
    logic [NCH-1:0] active;
    logic [NCH-1:0] pend_clr;
    logic [NCH-1:0] ovf_clr;
    logic [NCH-1:0] sw_set;
    logic [DW-1:0]  pend8, mask8, ovf8, pol8;
    logic [2:0]     vec_idx;
    logic           found;
    logic [DW-1:0]  rd_data;
    logic           unused_din;

    assign we = bus.cs & bus.wr & bus.cen;

    assign pend_clr = (we && bus.addr == PEND) ? bus.din[NCH-1:0] : '0;
    assign ovf_clr  = (we && bus.addr == OVF)  ? bus.din[NCH-1:0] : '0;
    assign sw_set   = (we && bus.addr == SET)  ? bus.din[NCH-1:0] : '0;

    // Upper data bits are not backed by any register for NCH < 8.
    assign unused_din = ^bus.din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask     <= MASK_RST[NCH-1:0];
            polarity <= '0;
        end else if (we) begin
            case (bus.addr)
                MASK:    mask     <= bus.din[NCH-1:0];
                POL:     polarity <= bus.din[NCH-1:0];
                default: ;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            jtdd_irqctl_ch #(
                .SYNC (SYNC)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .irq_in   (irq_in[i]),
                .polarity (polarity[i]),
                .sw_set   (sw_set[i]),
                .pend_clr (pend_clr[i]),
                .ovf_clr  (ovf_clr[i]),
                .pending  (pending[i]),
                .overflow (overflow[i])
            );
        end
    endgenerate

    assign active  = pending & mask;
    assign irq_n   = ~active;
    assign any_irq = |active;

    always_comb begin
        vec_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (active[i] && !found) begin
                vec_idx = 3'(i);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        pend8 = '0;
        mask8 = '0;
        ovf8  = '0;
        pol8  = '0;
        pend8[NCH-1:0] = pending;
        mask8[NCH-1:0] = mask;
        ovf8[NCH-1:0]  = overflow;
        pol8[NCH-1:0]  = polarity;
        case (bus.addr)
            PEND:    rd_data = pend8;
            MASK:    rd_data = mask8;
            SET:     rd_data = '0;
            OVF:     rd_data = ovf8;
            VEC:     rd_data = {any_irq, 4'b0000, vec_idx};
            POL:     rd_data = pol8;
            default: rd_data = '1;
        endcase
    end

    assign bus.dout = rd_data;

endmodule

// File: tb/tb_jtdd_irqctl.sv
// Directed self-checking bench for jtdd_irqctl (NCH=3, SYNC=1, MASK_RST=FF).
module tb_jtdd_irqctl;
    import jtdd_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] irq_in = '0;
    logic [2:0] irq_n;
    logic       any_irq;
    logic [7:0] v;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    jtdd_irqctl_if bus ();

    jtdd_irqctl #(
        .NCH      (3),
        .MASK_RST (8'hFF),
        .SYNC     (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .bus     (bus),
        .irq_n   (irq_n),
        .any_irq (any_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.din = d;
        tick();
        bus.cs = 1'b0; bus.wr = 1'b0; bus.din = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus.cs = 1'b1; bus.wr = 1'b0; bus.addr = a;
        #1;
        d = bus.dout;
        bus.cs = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.cen = 1'b1; bus.cs = 1'b0; bus.wr = 1'b0;
        bus.addr = '0;  bus.din = '0;

        // Reset state
        #12;
        chk("rst_irq_n", {5'b0, irq_n}, 8'h07);
        chk("rst_any", {7'b0, any_irq}, 8'h00);
        rd(PEND, v); chk("rst_pend", v, 8'h00);
        rd(MASK, v); chk("rst_mask", v, 8'h07);
        rd(POL, v);  chk("rst_pol", v, 8'h00);
        rd(VEC, v);  chk("rst_vec", v, 8'h00);
        rd(3'd7, v); chk("rd_addr7", v, 8'hFF);
        tick();
        rst = 1'b0;
        tick();

        // Write without cen is ignored
        bus.cen = 1'b0;
        wr_reg(MASK, 8'h00);
        bus.cen = 1'b1;
        rd(MASK, v); chk("cen0_mask", v, 8'h07);

        // Rising pulse on ch1: pending on 3rd edge
        irq_in[1] = 1'b1;
        ticks(2);
        rd(PEND, v); chk("sync_2clk_pend", v, 8'h00);
        tick();
        rd(PEND, v); chk("sync_3clk_pend", v, 8'h02);
        chk("ch1_irq_n", {5'b0, irq_n}, 8'h05);
        rd(VEC, v);  chk("ch1_vec", v, 8'h81);
        irq_in[1] = 1'b0;
        ticks(3);

        // Second edge before clear -> overflow; W1C clears it
        irq_in[1] = 1'b1;
        ticks(3);
        rd(OVF, v); chk("ovf_set", v, 8'h02);
        wr_reg(OVF, 8'h02);
        rd(OVF, v);  chk("ovf_w1c", v, 8'h00);
        rd(PEND, v); chk("pend_kept", v, 8'h02);
        irq_in[1] = 1'b0;
        wr_reg(PEND, 8'h02);
        rd(PEND, v); chk("pend_w1c", v, 8'h00);
        chk("idle_irq_n", {5'b0, irq_n}, 8'h07);
        ticks(2);

        // Edge on ch0 coinciding with W1C of ch0
        wr_reg(SET, 8'h01);
        rd(PEND, v); chk("swset_ch0", v, 8'h01);
        irq_in[0] = 1'b1;
        ticks(2);
        wr_reg(PEND, 8'h01);
        rd(PEND, v); chk("clr_vs_edge_pend", v, 8'h01);
        rd(OVF, v);  chk("clr_vs_edge_ovf", v, 8'h00);
        irq_in[0] = 1'b0;
        ticks(3);
        wr_reg(PEND, 8'h01);
        rd(PEND, v); chk("ch0_cleared", v, 8'h00);

        // Software set + hardware edge together on ch2 (pending was 0)
        irq_in[2] = 1'b1;
        ticks(2);
        wr_reg(SET, 8'h04);
        rd(PEND, v); chk("set_edge_pend", v, 8'h04);
        rd(OVF, v);  chk("set_edge_ovf", v, 8'h00);
        wr_reg(SET, 8'h04);
        rd(OVF, v);  chk("swset_ovf", v, 8'h04);
        irq_in[2] = 1'b0;
        wr_reg(OVF, 8'h04);
        wr_reg(PEND, 8'h04);
        ticks(2);
        rd(PEND, v); chk("ch2_cleared", v, 8'h00);

        // Masked channels stay pending; unmask ch2
        wr_reg(MASK, 8'h00);
        irq_in[0] = 1'b1; irq_in[2] = 1'b1;
        ticks(3);
        chk("masked_irq_n", {5'b0, irq_n}, 8'h07);
        chk("masked_any", {7'b0, any_irq}, 8'h00);
        rd(PEND, v); chk("masked_pend", v, 8'h05);
        rd(VEC, v);  chk("masked_vec", v, 8'h00);
        wr_reg(MASK, 8'h04);
        chk("unmask_irq_n", {5'b0, irq_n}, 8'h03);
        rd(VEC, v);  chk("unmask_vec", v, 8'h82);
        rd(MASK, v); chk("mask_rb", v, 8'h04);
        irq_in[0] = 1'b0; irq_in[2] = 1'b0;
        ticks(2);
        wr_reg(PEND, 8'h05);
        wr_reg(MASK, 8'hFF);
        rd(MASK, v); chk("mask_upper_ignored", v, 8'h07);
        ticks(2);

        // Falling-edge polarity on ch0
        wr_reg(POL, 8'h01);
        rd(POL, v); chk("pol_rb", v, 8'h01);
        irq_in[0] = 1'b1;
        ticks(4);
        rd(PEND, v); chk("pol_rise_noevt", v, 8'h00);
        irq_in[0] = 1'b0;
        ticks(3);
        rd(PEND, v); chk("pol_fall_evt", v, 8'h01);
        chk("pol_irq_n", {5'b0, irq_n}, 8'h06);
        wr_reg(PEND, 8'h01);
        wr_reg(POL, 8'h00);
        tick();
        rd(PEND, v); chk("pol_wr_noevt", v, 8'h00);

        // Reset during a write
        wr_reg(SET, 8'h07);
        rd(PEND, v); chk("pre_rst_pend", v, 8'h07);
        chk("pre_rst_irq_n", {5'b0, irq_n}, 8'h00);
        bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = MASK; bus.din = 8'h00;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_irq_n", {5'b0, irq_n}, 8'h07);
        chk("rst_async_any", {7'b0, any_irq}, 8'h00);
        tick();
        bus.cs = 1'b0; bus.wr = 1'b0;
        rst = 1'b0;
        rd(MASK, v); chk("abort_mask", v, 8'h07);
        rd(PEND, v); chk("abort_pend", v, 8'h00);
        tick();
        chk("post_rst_irq_n", {5'b0, irq_n}, 8'h07);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
